// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: single-clock video raster generator with selectable test
// patterns. Raster counters (cx, cy) run free; the pattern is computed from the
// current counters and delayed LATENCY clocks onto rgb/de/new_frame.
// There is no valid/ready handshake: every clock produces one pixel, and
// new_frame marks the first pixel of a frame after the same LATENCY delay.
module hdmi_pattern_gen #(
  parameter int SCREEN_WIDTH  = 720,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FRAME_WIDTH   = 858,
  parameter int FRAME_HEIGHT  = 525,
  parameter int BIT_WIDTH     = 10,
  parameter int BIT_HEIGHT    = 10,
  parameter int LATENCY       = 2,
  parameter int CHECKER_LOG2  = 4,
  parameter int SCROLL_STEP   = 4
) (
  input  logic                  clk_hdmi,
  input  logic                  rst_hdmi,
  input  logic [2:0]            mode,
  input  logic [23:0]           solid_rgb,
  input  logic                  freeze,
  output logic [BIT_WIDTH-1:0]  cx,
  output logic [BIT_HEIGHT-1:0] cy,
  output logic                  de,
  output logic                  new_frame,
  output logic [23:0]           rgb,
  output logic [7:0]            frame_count
);

  // Width of one colour bar; clamped so a tiny screen still counts sanely.
  localparam int BAR_W = (SCREEN_WIDTH / 8 > 0) ? SCREEN_WIDTH / 8 : 1;
  // Moving bar is this many pixels wide.
  localparam int MBAR_W = 16;

  logic                 line_end;
  logic                 frame_end;
  logic [2:0]           active_mode;
  logic [BIT_WIDTH-1:0] scroll;
  logic [BIT_WIDTH:0]   scroll_sum;
  logic [BIT_WIDTH-1:0] bar_pos;
  logic [2:0]           bar_idx;

  // 32-bit views so comparisons against integer parameters stay width-clean.
  logic [31:0] cx_w;
  logic [31:0] cy_w;
  logic [31:0] scroll_w;
  logic [31:0] mbar_dist;

  logic        active;
  logic        nf;
  logic [23:0] pix;
  logic [23:0] bar_rgb;

  logic [25:0] pipe [LATENCY];

  assign line_end  = (cx == BIT_WIDTH'(FRAME_WIDTH - 1));
  assign frame_end = line_end && (cy == BIT_HEIGHT'(FRAME_HEIGHT - 1));

  assign cx_w     = 32'(cx);
  assign cy_w     = 32'(cy);
  assign scroll_w = 32'(scroll);

  assign scroll_sum = {1'b0, scroll} + (BIT_WIDTH + 1)'(SCROLL_STEP);

  // Raster counters: cx runs every clock, cy steps at end of line, both wrap at frame end.
  always_ff @(posedge clk_hdmi) begin
    if (rst_hdmi) begin
      cx <= '0;
      cy <= '0;
    end else if (line_end) begin
      cx <= '0;
      cy <= frame_end ? '0 : cy + 1'b1;
    end else begin
      cx <= cx + 1'b1;
    end
  end

  // Per-frame state: mode is latched only at frame boundaries; count/scroll obey freeze.
  always_ff @(posedge clk_hdmi) begin
    if (rst_hdmi) begin
      frame_count <= '0;
      scroll      <= '0;
      active_mode <= mode;
    end else if (frame_end) begin
      active_mode <= mode;
      if (!freeze) begin
        frame_count <= frame_count + 8'd1;
        if (scroll_sum >= (BIT_WIDTH + 1)'(SCREEN_WIDTH))
          scroll <= BIT_WIDTH'(scroll_sum - (BIT_WIDTH + 1)'(SCREEN_WIDTH));
        else
          scroll <= BIT_WIDTH'(scroll_sum);
      end
    end
  end

  // Colour-bar index tracks cx without a divider: a position counter inside the
  // current bar, and a bar index that saturates at 7 so leftover pixels are black.
  always_ff @(posedge clk_hdmi) begin
    if (rst_hdmi || line_end) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_pos == BIT_WIDTH'(BAR_W - 1)) begin
      bar_pos <= '0;
      bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
    end else begin
      bar_pos <= bar_pos + 1'b1;
    end
  end

  // Bar colour lookup for the colour-bar pattern.
  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hffffff;
      3'd1: bar_rgb = 24'hffff00;
      3'd2: bar_rgb = 24'h00ffff;
      3'd3: bar_rgb = 24'h00ff00;
      3'd4: bar_rgb = 24'hff00ff;
      3'd5: bar_rgb = 24'hff0000;
      3'd6: bar_rgb = 24'h0000ff;
      default: bar_rgb = 24'h000000;
    endcase
  end

  // Pattern stage 0: active/nf flags and the gated pixel colour for the current counters.
  always_comb begin
    active    = (cx_w < SCREEN_WIDTH) && (cy_w < SCREEN_HEIGHT);
    nf        = (cx == '0) && (cy == '0);
    mbar_dist = (cx_w >= scroll_w) ? (cx_w - scroll_w)
                                   : (cx_w + SCREEN_WIDTH - scroll_w);
    pix       = 24'h000000;
    case (active_mode)
      3'd0: pix = solid_rgb;
      3'd1: pix = bar_rgb;
      3'd2: pix = (cx_w[CHECKER_LOG2] ^ cy_w[CHECKER_LOG2]) ? 24'hffffff : 24'h000000;
      3'd3: pix = {cx_w[7:0], cy_w[7:0], frame_count};
      3'd4: pix = frame_count[0] ? 24'h00ff00 : 24'hff00ff;
      3'd5: pix = (mbar_dist < MBAR_W) ? 24'hffffff : 24'h000000;
      default: pix = 24'h000000;
    endcase
    if (!active)
      pix = 24'h000000;
  end

  // Output pipeline: LATENCY register stages carrying {rgb, active, nf}.
  always_ff @(posedge clk_hdmi) begin
    if (rst_hdmi) begin
      for (int i = 0; i < LATENCY; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= {pix, active, nf};
      for (int i = 1; i < LATENCY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign {rgb, de, new_frame} = pipe[LATENCY-1];

endmodule
